// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, DBIT data bits, SB_TICK stop ticks.
// Optional parity stage and par_err port when UART_RX_PARITY_EN is defined.
module uart_rx #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_tick,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       rx_done_tick,
   output logic       frame_err,
   output logic       busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic       par_err
`endif
);

   // Parameter legality is checked once, at elaboration.
   if (DBIT < 5 || DBIT > 8 || SB_TICK < 1 || SB_TICK > 16 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_rx: illegal parameter value");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP,
      ST_BRK
   } state_t;

   localparam logic [3:0] LP_MID   = 4'd7;
   localparam logic [3:0] LP_LAST  = 4'd15;
   localparam logic [3:0] LP_STOP  = 4'(SB_TICK - 1);
   localparam logic [2:0] LP_NLAST = 3'(DBIT - 1);

   state_t          r_state;
   logic [3:0]      r_s;
   logic [2:0]      r_n;
   logic [DBIT-1:0] r_b;
   logic            r_rx_meta;
   logic            r_rx_s;
   logic [7:0]      r_dout;
   logic            r_done;
   logic            r_ferr;

`ifdef UART_RX_PARITY_EN
   localparam logic LP_PAR_ODD = 1'(PARITY_ODD);
   logic            r_par;
   logic            r_perr;
   logic            w_par_bad;

   assign w_par_bad = ((^r_b) ^ r_par) != LP_PAR_ODD;
   assign par_err   = r_perr;
`endif

   assign dout         = r_dout;
   assign rx_done_tick = r_done;
   assign frame_err    = r_ferr;
   assign busy         = (r_state != ST_IDLE);

   // Two-flop synchroniser for the asynchronous rx pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // Frame state machine with registered byte, flags and done strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
         r_dout  <= '0;
         r_done  <= 1'b0;
         r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par   <= 1'b0;
         r_perr  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (!r_rx_s) begin
                  r_state <= ST_START;
                  r_s     <= '0;
               end
            end
            ST_START: begin
               if (s_tick) begin
                  if (r_s == LP_MID) begin
                     if (!r_rx_s) begin
                        r_state <= ST_DATA;
                        r_s     <= '0;
                        r_n     <= '0;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
            end
            ST_DATA: begin
               if (s_tick) begin
                  if (r_s == LP_LAST) begin
                     r_b <= {r_rx_s, r_b[DBIT-1:1]};
                     r_s <= '0;
                     if (r_n == LP_NLAST) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= ST_PAR;
`else
                        r_state <= ST_STOP;
`endif
                     end else begin
                        r_n <= r_n + 3'd1;
                     end
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
            end
            ST_PAR: begin
`ifdef UART_RX_PARITY_EN
               if (s_tick) begin
                  if (r_s == LP_LAST) begin
                     r_par   <= r_rx_s;
                     r_s     <= '0;
                     r_state <= ST_STOP;
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
`else
               r_state <= ST_IDLE;
`endif
            end
            ST_STOP: begin
               if (s_tick) begin
                  if (r_s == LP_STOP) begin
                     r_dout <= 8'(r_b);
                     r_ferr <= ~r_rx_s;
                     r_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     r_perr <= w_par_bad;
`endif
                     r_state <= r_rx_s ? ST_IDLE : ST_BRK;
                  end else begin
                     r_s <= r_s + 4'd1;
                  end
               end
            end
            ST_BRK: begin
               if (r_rx_s) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
